// File: rtl/mood_pkg.sv
// mood_pkg: encodings shared with the mood chip (state codes, event kinds)
// and the rule that turns the asleep/dying flags into a physical state.
package mood_pkg;

  localparam logic [1:0] AWAKE  = 2'b00;
  localparam logic [1:0] ASLEEP = 2'b01;
  localparam logic [1:0] DYING  = 2'b10;
  localparam logic [1:0] DEAD   = 2'b11;

  typedef enum logic [1:0] {
    ST_AWAKE  = AWAKE,
    ST_ASLEEP = ASLEEP,
    ST_DYING  = DYING,
    ST_DEAD   = DEAD
  } mood_state_e;

  localparam logic [1:0] EVT_EMOTION = 2'd0;
  localparam logic [1:0] EVT_STATE   = 2'd1;
  localparam logic [1:0] EVT_HB_LOST = 2'd2;

  // kind + payload byte
  localparam int EVT_W = 10;

  // dying outranks asleep; neither flag means awake
  function automatic mood_state_e infer_state(input logic asleep, input logic dying);
    mood_state_e s;
    s = ST_AWAKE;
    if (dying) s = ST_DYING;
    else if (asleep) s = ST_ASLEEP;
    return s;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: small shift-style synchronous FIFO. Entry 0 is always the
// head, so the head output comes straight from a flop and holds steady
// while the consumer stalls.
module event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;
  logic [AW-1:0]    wr_idx;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign wr_idx  = do_pop ? AW'(count - CW'(1)) : AW'(count);
  assign head    = mem[0];

  // storage shifts toward the head on pop; new entry lands behind the last valid one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (do_push) mem[wr_idx] <= push_data;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mood_monitor.sv
// mood_monitor: host-side receiver for the mood chip. Synchronises the chip
// outputs, debounces the emotion bus, infers the physical state (including
// DEAD on heartbeat loss), measures the heartbeat period and queues change
// events for the host.
// Optional build macro MOOD_MONITOR_TS_EN adds a 16-bit wrapping timestamp
// to each queued event, presented on evt_ts.
//
// state  | meaning
// AWAKE  | heartbeat alive, no flags set
// ASLEEP | heartbeat alive, asleep flag set
// DYING  | heartbeat alive, dying flag set (wins over asleep)
// DEAD   | reset, or no heartbeat edge for HB_TIMEOUT cycles; left on next edge
module mood_monitor
  import mood_pkg::*;
#(
  parameter int STABLE_CNT = 3,
  parameter int HB_TIMEOUT = 4096,
  parameter int PERIOD_W   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          emotion_in,
  input  logic                asleep_in,
  input  logic                dying_in,
  input  logic                heartbeat_in,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_kind,
  output logic [7:0]          evt_data,
  output logic [1:0]          state,
  output logic [7:0]          emotion,
  output logic [PERIOD_W-1:0] hb_period,
  output logic                hb_period_valid,
  output logic                overflow,
`ifdef MOOD_MONITOR_TS_EN
  output logic [15:0]         evt_ts,
`endif
  input  logic                clr_overflow
);

  localparam int TO_W  = $clog2(HB_TIMEOUT + 1);
  localparam int CNT_W = 4;
`ifdef MOOD_MONITOR_TS_EN
  localparam int ENTRY_W = EVT_W + 16;
`else
  localparam int ENTRY_W = EVT_W;
`endif

  logic [7:0]          emo_s1, emo_s2;
  logic [2:0]          ctl_s1, ctl_s2;  // {heartbeat, dying, asleep}
  logic                hb_prev, hb_edge, hb_seen;
  logic [7:0]          cand, emotion_q;
  logic [CNT_W-1:0]    stable_cnt;
  logic                emo_accept;
  logic [PERIOD_W-1:0] per_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                timeout;
  mood_state_e         state_q, state_d;
  logic                lost_pend, state_pend, emo_pend;
  logic                sel_lost, sel_state, sel_emo;
  logic                push, drop, fifo_full, fifo_empty;
  logic [1:0]          push_kind;
  logic [7:0]          push_data;
  logic [ENTRY_W-1:0]  push_entry, head_entry;

  // two-flop synchronisers on every chip output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emo_s1  <= '0;
      emo_s2  <= '0;
      ctl_s1  <= '0;
      ctl_s2  <= '0;
      hb_prev <= 1'b0;
    end else begin
      emo_s1  <= emotion_in;
      emo_s2  <= emo_s1;
      ctl_s1  <= {heartbeat_in, dying_in, asleep_in};
      ctl_s2  <= ctl_s1;
      hb_prev <= ctl_s2[2];
    end
  end

  assign hb_edge    = ctl_s2[2] && !hb_prev;
  assign emo_accept = (stable_cnt >= CNT_W'(STABLE_CNT)) && (cand != emotion_q);

  // emotion debounce: a value must repeat STABLE_CNT samples before it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand       <= '0;
      stable_cnt <= '0;
      emotion_q  <= '0;
    end else begin
      if (emo_s2 != cand) begin
        cand       <= emo_s2;
        stable_cnt <= CNT_W'(1);
      end else if (stable_cnt != '1) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
      if (emo_accept) emotion_q <= cand;
    end
  end

  // heartbeat period: the first edge after reset or DEAD only arms the measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt         <= '0;
      hb_period       <= '0;
      hb_period_valid <= 1'b0;
      hb_seen         <= 1'b0;
    end else begin
      hb_period_valid <= 1'b0;
      if (hb_edge) begin
        per_cnt <= '0;
        hb_seen <= 1'b1;
        if (hb_seen) begin
          hb_period       <= (&per_cnt) ? per_cnt : per_cnt + PERIOD_W'(1);
          hb_period_valid <= 1'b1;
        end
      end else begin
        if (!(&per_cnt)) per_cnt <= per_cnt + PERIOD_W'(1);
        if (timeout) hb_seen <= 1'b0;
      end
    end
  end

  // HB_TIMEOUT edge-free cycles while alive declare the chip dead
  assign timeout = (state_q != ST_DEAD) && !hb_edge && (to_cnt == TO_W'(HB_TIMEOUT - 1));

  // heartbeat loss timer; frozen while DEAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt <= '0;
    else if (hb_edge) to_cnt <= '0;
    else if (state_q != ST_DEAD) to_cnt <= to_cnt + TO_W'(1);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_DEAD;
    else state_q <= state_d;
  end

  // next state: DEAD sticks until a heartbeat edge, otherwise follow the flags
  always_comb begin
    state_d = state_q;
    if (timeout) state_d = ST_DEAD;
    else if (state_q != ST_DEAD || hb_edge) state_d = infer_state(ctl_s2[0], ctl_s2[1]);
  end

  // one event per cycle; payload is whatever is current when it is pushed
  always_comb begin
    push      = 1'b0;
    push_kind = EVT_EMOTION;
    push_data = emotion_q;
    sel_lost  = 1'b0;
    sel_state = 1'b0;
    sel_emo   = 1'b0;
    if (lost_pend) begin
      push      = 1'b1;
      sel_lost  = 1'b1;
      push_kind = EVT_HB_LOST;
      push_data = {6'b0, state_q};
    end else if (state_pend) begin
      push      = 1'b1;
      sel_state = 1'b1;
      push_kind = EVT_STATE;
      push_data = {6'b0, state_q};
    end else if (emo_pend) begin
      push      = 1'b1;
      sel_emo   = 1'b1;
    end
  end

  // pending flags clear once their event is offered to the FIFO, kept or dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_pend  <= 1'b0;
      state_pend <= 1'b0;
      emo_pend   <= 1'b0;
    end else begin
      lost_pend  <= (lost_pend && !sel_lost) || timeout;
      state_pend <= (state_pend && !sel_state) || (state_d != state_q);
      emo_pend   <= (emo_pend && !sel_emo) || emo_accept;
    end
  end

  assign drop = push && fifo_full && !evt_ready;

  // sticky overflow; a drop in the clearing cycle keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

`ifdef MOOD_MONITOR_TS_EN
  logic [15:0] ts_cnt;

  // free-running wrapping timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else ts_cnt <= ts_cnt + 16'd1;
  end

  assign push_entry = {ts_cnt, push_kind, push_data};
  assign evt_ts     = head_entry[ENTRY_W-1 -: 16];
`else
  assign push_entry = {push_kind, push_data};
`endif

  event_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (evt_ready),
    .head     (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_kind  = head_entry[9:8];
  assign evt_data  = head_entry[7:0];
  assign state     = state_q;
  assign emotion   = emotion_q;

endmodule
